// File: rtl/sprite_fifo_pkg.sv
// sprite_fifo_pkg
//   Shared types and constants for the sprite pixel FIFO and its row aligner.
//   sprite_px_t       : one queued sprite pixel {color, attr} at default widths.
//   SPR_ATTR_PALETTE  : attribute bit selecting OBP0/OBP1.
//   SPR_ATTR_PRIORITY : attribute bit giving background priority over the sprite.
//   is_transparent()  : color index 0 is transparent.
package sprite_fifo_pkg;

    localparam int SPR_PIX_W         = 2;
    localparam int SPR_ATTR_W        = 2;
    localparam int SPR_ATTR_PALETTE  = 0;
    localparam int SPR_ATTR_PRIORITY = 1;

    // Widest color index the helper accepts; callers zero-extend into it.
    localparam int SPR_COLOR_MAX_W   = 8;

    typedef struct packed {
        logic [SPR_PIX_W-1:0]  color;
        logic [SPR_ATTR_W-1:0] attr;
    } sprite_px_t;

    function automatic logic is_transparent(input logic [SPR_COLOR_MAX_W-1:0] color);
        return color == '0;
    endfunction

endpackage

// File: rtl/sprite_row_align.sv
// sprite_row_align
//   Combinational X-flip and left-edge clip of one fetched sprite row.
//   pixels_in  : ROW pixels, pixel i at [i*PIX_W +: PIX_W], pixel 0 leftmost.
//   flip_in    : mirror the row (pixel i -> ROW-1-i).
//   skip_in    : leading pixels dropped after the flip; >= ROW drops all.
//   pixels_out : aligned row, dropped pixels removed from the front, zero tail.
//   len_out    : number of surviving pixels, ROW - min(skip_in, ROW).
module sprite_row_align #(
    parameter int ROW    = 8,
    parameter int PIX_W  = 2,
    parameter int SKIP_W = $clog2(ROW) + 1
) (
    input  logic [ROW*PIX_W-1:0] pixels_in,
    input  logic                 flip_in,
    input  logic [SKIP_W-1:0]    skip_in,
    output logic [ROW*PIX_W-1:0] pixels_out,
    output logic [SKIP_W-1:0]    len_out
);

    logic [ROW*PIX_W-1:0] flipped;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        flipped = pixels_in;
        if (flip_in) begin
            for (int i = 0; i < ROW; i++) begin
                flipped[i*PIX_W +: PIX_W] = pixels_in[(ROW-1-i)*PIX_W +: PIX_W];
            end
        end
    end

    // Pixel 0 sits in the LSBs, so dropping leading pixels is a right shift of
    // the flat vector; a shift of ROW or more pixels yields all zeros.
    assign pixels_out = flipped >> (32'(skip_in) * PIX_W);
    assign len_out    = (skip_in >= SKIP_W'(ROW)) ? '0 : SKIP_W'(ROW) - skip_in;

endmodule

// File: rtl/sprite_mix_fifo.sv
// sprite_mix_fifo
//   Sprite pixel FIFO with DMG overlap merge. Whole aligned rows are merged
//   into the queue (earlier sprite wins unless transparent); the mixer pops
//   one pixel per T-cycle. DEPTH must be >= ROW so a row never overflows.
//   clk_in/rst_in      : clock, synchronous active-high reset.
//   tclk_in            : T-cycle enable for pop and push (not flush/reset).
//   flush_in           : clear all contents, suppress same-cycle pop/push.
//   row_*              : row offer from the sprite fetcher (valid/ready).
//   pop_in             : mixer pixel request.
//   pixel_out/attr_out : popped pixel, valid with the pixel_valid_out pulse.
//   occupancy_out      : queued pixel count; empty_out when zero.
module sprite_mix_fifo
    import sprite_fifo_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int DEPTH  = 8,
    parameter int PIX_W  = 2,
    parameter int ATTR_W = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       tclk_in,
    input  logic                       flush_in,
    input  logic                       row_valid_in,
    output logic                       row_ready_out,
    input  logic [ROW*PIX_W-1:0]       row_pixels_in,
    input  logic [ATTR_W-1:0]          row_attr_in,
    input  logic                       row_flip_in,
    input  logic [$clog2(ROW):0]       row_skip_in,
    input  logic                       pop_in,
    output logic [PIX_W-1:0]           pixel_out,
    output logic [ATTR_W-1:0]          attr_out,
    output logic                       pixel_valid_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_out,
    output logic                       empty_out
);

    localparam int SKIP_W = $clog2(ROW) + 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][PIX_W-1:0]  color_q, color_d;
    logic [DEPTH-1:0][ATTR_W-1:0] attr_q,  attr_d;
    logic [OCC_W-1:0]             occ_q,   occ_d;
    logic                         empty_q, empty_d;
    logic [PIX_W-1:0]             pix_q,   pix_d;
    logic [ATTR_W-1:0]            pattr_q, pattr_d;
    logic                         valid_q, valid_d;

    logic [ROW-1:0][PIX_W-1:0]    al_pixels;
    logic [SKIP_W-1:0]            al_len;
    logic [OCC_W-1:0]             len_occ;
    logic [OCC_W-1:0]             occ_mid;   // count after any same-cycle pop
    logic                         do_push;
    logic                         do_pop;

    sprite_row_align #(
        .ROW    (ROW),
        .PIX_W  (PIX_W),
        .SKIP_W (SKIP_W)
    ) u_align (
        .pixels_in  (row_pixels_in),
        .flip_in    (row_flip_in),
        .skip_in    (row_skip_in),
        .pixels_out (al_pixels),
        .len_out    (al_len)
    );

    assign row_ready_out = !rst_in && !flush_in;
    assign do_push       = row_valid_in && row_ready_out && tclk_in;
    assign do_pop        = pop_in && !flush_in && tclk_in;
    // L <= ROW <= DEPTH, so the length always fits the occupancy width.
    assign len_occ       = OCC_W'(al_len);

    always_comb begin
        color_d = color_q;
        attr_d  = attr_q;
        pix_d   = pix_q;
        pattr_d = pattr_q;
        valid_d = 1'b0;
        occ_mid = occ_q;

        if (flush_in) begin
            color_d = '0;
            attr_d  = '0;
            occ_mid = '0;
        end else begin
            // Pop first: the merge below works on the already-shifted array,
            // so the popped pixel can never be touched by the incoming row.
            if (do_pop) begin
                valid_d = 1'b1;
                if (occ_q != '0) begin
                    pix_d   = color_q[0];
                    pattr_d = attr_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        color_d[i] = color_q[i+1];
                        attr_d[i]  = attr_q[i+1];
                    end
                    color_d[DEPTH-1] = '0;
                    attr_d[DEPTH-1]  = '0;
                    occ_mid          = occ_q - 1'b1;
                end else begin
                    // Underrun: a transparent pixel lets the mixer fall
                    // through to background.
                    pix_d   = '0;
                    pattr_d = '0;
                end
            end

            if (do_push) begin
                for (int j = 0; j < ROW; j++) begin
                    if (SKIP_W'(j) < al_len) begin
                        // Free slots take the new pixel; occupied slots keep
                        // the earlier sprite unless it is transparent there.
                        if ((OCC_W'(j) >= occ_mid) ||
                            (is_transparent(SPR_COLOR_MAX_W'(color_d[j])) &&
                             !is_transparent(SPR_COLOR_MAX_W'(al_pixels[j])))) begin
                            color_d[j] = al_pixels[j];
                            attr_d[j]  = row_attr_in;
                        end
                    end
                end
            end
        end

        occ_d   = (do_push && (len_occ > occ_mid)) ? len_occ : occ_mid;
        empty_d = (occ_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the slot array is reset as well: it is only DEPTH small
            // registers, and cleared slots are what a later merge compares
            // against, so their contents must never be X.
            color_q <= '0;
            attr_q  <= '0;
            occ_q   <= '0;
            empty_q <= 1'b1;
            pix_q   <= '0;
            pattr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            color_q <= color_d;
            attr_q  <= attr_d;
            occ_q   <= occ_d;
            empty_q <= empty_d;
            pix_q   <= pix_d;
            pattr_q <= pattr_d;
            valid_q <= valid_d;
        end
    end

    assign pixel_out       = pix_q;
    assign attr_out        = pattr_q;
    assign pixel_valid_out = valid_q;
    assign occupancy_out   = occ_q;
    assign empty_out       = empty_q;

endmodule

// File: tb/tb_sprite_mix_fifo.sv
// tb_sprite_mix_fifo
//   Directed bench for sprite_mix_fifo with 3-bit colors so rows with colors
//   up to 7 fit. Stimulus pushes the expected popped pixel into a queue; a
//   monitor compares every pixel_valid_out pulse against the queue head.
module tb_sprite_mix_fifo;
    import sprite_fifo_pkg::*;

    localparam int ROW    = 8;
    localparam int DEPTH  = 8;
    localparam int PIX_W  = 3;
    localparam int ATTR_W = 2;

    typedef struct {
        logic [PIX_W-1:0]  c;
        logic [ATTR_W-1:0] a;
    } exp_t;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 tclk_in;
    logic                 flush_in;
    logic                 row_valid_in;
    logic                 row_ready_out;
    logic [ROW*PIX_W-1:0] row_pixels_in;
    logic [ATTR_W-1:0]    row_attr_in;
    logic                 row_flip_in;
    logic [3:0]           row_skip_in;
    logic                 pop_in;
    logic [PIX_W-1:0]     pixel_out;
    logic [ATTR_W-1:0]    attr_out;
    logic                 pixel_valid_out;
    logic [3:0]           occupancy_out;
    logic                 empty_out;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    sprite_mix_fifo #(
        .ROW(ROW), .DEPTH(DEPTH), .PIX_W(PIX_W), .ATTR_W(ATTR_W)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tclk_in         (tclk_in),
        .flush_in        (flush_in),
        .row_valid_in    (row_valid_in),
        .row_ready_out   (row_ready_out),
        .row_pixels_in   (row_pixels_in),
        .row_attr_in     (row_attr_in),
        .row_flip_in     (row_flip_in),
        .row_skip_in     (row_skip_in),
        .pop_in          (pop_in),
        .pixel_out       (pixel_out),
        .attr_out        (attr_out),
        .pixel_valid_out (pixel_valid_out),
        .occupancy_out   (occupancy_out),
        .empty_out       (empty_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row from hex nibbles: nibble i (low 3 bits) is pixel i, pixel 0 leftmost.
    function automatic logic [ROW*PIX_W-1:0] mk_row(input logic [31:0] nib);
        logic [ROW*PIX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROW; i++) r[i*PIX_W +: PIX_W] = nib[i*4 +: PIX_W];
        return r;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_row(input logic [31:0] nib, input logic [1:0] attr,
                            input logic flip, input logic [3:0] skip);
        row_pixels_in = mk_row(nib);
        row_attr_in   = attr;
        row_flip_in   = flip;
        row_skip_in   = skip;
        row_valid_in  = 1'b1;
        tclk_in       = 1'b1;
        step();
        row_valid_in  = 1'b0;
    endtask

    task automatic do_pop(input logic [PIX_W-1:0] c, input logic [1:0] a);
        exp_t e;
        e.c = c;
        e.a = a;
        exp_q.push_back(e);
        pop_in  = 1'b1;
        tclk_in = 1'b1;
        step();
        pop_in  = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest expected pixel.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (pixel_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(pixel_valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_color", 32'(pixel_out), 32'(e.c));
                    check("pop_attr",  32'(attr_out),  32'(e.a));
                end
            end
        end
    end

    initial begin
        rst_in = 1'b1; tclk_in = 1'b1; flush_in = 1'b0; row_valid_in = 1'b0;
        row_pixels_in = '0; row_attr_in = '0; row_flip_in = 1'b0;
        row_skip_in = '0; pop_in = 1'b0;

        // Reset state.
        step(); step();
        check("rst_ready",  32'(row_ready_out),   32'd0);
        check("rst_pixel",  32'(pixel_out),       32'd0);
        check("rst_attr",   32'(attr_out),        32'd0);
        check("rst_valid",  32'(pixel_valid_out), 32'd0);
        check("rst_occ",    32'(occupancy_out),   32'd0);
        check("rst_empty",  32'(empty_out),       32'd1);
        rst_in = 1'b0;
        step();
        check("ready_after_rst", 32'(row_ready_out), 32'd1);

        // Single row: colors 3,2,1,0 twice, attr 01.
        push_row(32'h0123_0123, 2'b01, 1'b0, 4'd0);
        check("t1_occ", 32'(occupancy_out), 32'd8);
        check("t1_not_empty", 32'(empty_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            do_pop(3'(3 - (k % 4)), 2'b01);
            check("t1_occ_dec", 32'(occupancy_out), 32'(7 - k));
        end
        check("t1_empty", 32'(empty_out), 32'd1);

        // Flip + skip: colors 1..7,0 flipped -> 0,7,6,5,4,3,2,1; drop 3 -> 5,4,3,2,1.
        push_row(32'h0765_4321, 2'b00, 1'b1, 4'd3);
        check("t2_occ", 32'(occupancy_out), 32'd5);
        do_pop(3'd5, 2'b00);
        do_pop(3'd4, 2'b00);
        do_pop(3'd3, 2'b00);
        do_pop(3'd2, 2'b00);
        do_pop(3'd1, 2'b00);
        do_pop(3'd0, 2'b00);   // underrun still pulses with color 0
        check("t2_occ_end", 32'(occupancy_out), 32'd0);

        // Overlap: A = 0,2,0,2,... pop 2 leaves 0,2,0,2,0,2; B = all 3 attr 10
        // fills the transparent slots and the two free tail slots.
        push_row(32'h2020_2020, 2'b00, 1'b0, 4'd0);
        do_pop(3'd0, 2'b00);
        do_pop(3'd2, 2'b00);
        check("t3_occ_mid", 32'(occupancy_out), 32'd6);
        push_row(32'h3333_3333, 2'b10, 1'b0, 4'd0);
        check("t3_occ", 32'(occupancy_out), 32'd8);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) do_pop(3'd3, 2'b10);
            else            do_pop(3'd2, 2'b00);
        end
        do_pop(3'd3, 2'b10);
        do_pop(3'd3, 2'b10);

        // Single pixel: skip 7 keeps only pixel 7 (color 1); skip 8 is empty.
        push_row(32'h1000_0000, 2'b01, 1'b0, 4'd7);
        check("t4_occ_one", 32'(occupancy_out), 32'd1);
        push_row(32'h7777_7777, 2'b11, 1'b0, 4'd8);
        check("t4_empty_row", 32'(occupancy_out), 32'd1);

        // Simultaneous pop + push of all-2: pop sees color 1, queue refills to 8.
        begin
            exp_t e;
            e.c = 3'd1;
            e.a = 2'b01;
            exp_q.push_back(e);
        end
        row_pixels_in = mk_row(32'h2222_2222);
        row_attr_in = 2'b00; row_flip_in = 1'b0; row_skip_in = 4'd0;
        row_valid_in = 1'b1; pop_in = 1'b1; tclk_in = 1'b1;
        step();
        row_valid_in = 1'b0; pop_in = 1'b0;
        check("t4_occ_full", 32'(occupancy_out), 32'd8);
        for (int k = 0; k < 8; k++) do_pop(3'd2, 2'b00);

        // Flush with a pop pending: no pulse, contents gone.
        push_row(32'h0765_4321, 2'b00, 1'b1, 4'd3);
        check("t5_occ5", 32'(occupancy_out), 32'd5);
        flush_in = 1'b1; pop_in = 1'b1; tclk_in = 1'b1;
        #1;
        check("t5_flush_ready", 32'(row_ready_out), 32'd0);
        step();
        flush_in = 1'b0; pop_in = 1'b0;
        check("t5_flush_valid", 32'(pixel_valid_out), 32'd0);
        check("t5_flush_occ",   32'(occupancy_out),   32'd0);
        check("t5_flush_empty", 32'(empty_out),       32'd1);

        // Enable low: push and pop ignored.
        push_row(32'h1111_1111, 2'b01, 1'b0, 4'd0);
        row_valid_in = 1'b1; pop_in = 1'b1; tclk_in = 1'b0;
        row_pixels_in = mk_row(32'h4444_4444);
        step();
        row_valid_in = 1'b0; pop_in = 1'b0;
        check("t5_hold_occ",   32'(occupancy_out),   32'd8);
        check("t5_hold_valid", 32'(pixel_valid_out), 32'd0);
        // Flush acts even with tclk_in low.
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("t5_flush_notclk", 32'(occupancy_out), 32'd0);

        // Reset during an accepted push and pop; pixel_out currently holds 2.
        push_row(32'h5555_5555, 2'b11, 1'b0, 4'd0);
        rst_in = 1'b1; row_valid_in = 1'b1; pop_in = 1'b1; tclk_in = 1'b1;
        #1;
        check("t6_ready_in_rst", 32'(row_ready_out), 32'd0);
        step();
        row_valid_in = 1'b0; pop_in = 1'b0;
        check("t6_pixel", 32'(pixel_out),       32'd0);
        check("t6_attr",  32'(attr_out),        32'd0);
        check("t6_valid", 32'(pixel_valid_out), 32'd0);
        check("t6_occ",   32'(occupancy_out),   32'd0);
        check("t6_empty", 32'(empty_out),       32'd1);
        rst_in = 1'b0;
        step();
        check("t6_ready_after", 32'(row_ready_out), 32'd1);

        step(); step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
